// File: rtl/mux_display_pkg.sv
// Shared types and the hex-to-7-segment pattern table for the multiplexed display.
package mux_display_pkg;

    typedef enum logic {BLANK = 1'b0, ON = 1'b1} mux_state_t;

    // Active-high patterns, bit 6 = g ... bit 0 = a, index = hex value.
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_decoder
    import mux_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = HEX7[value];

endmodule

// File: rtl/multiplex_display_n.sv
// N-digit time-multiplexed 7-segment driver with blanking gap, leading-zero
// suppression, per-digit enable and frame-synchronous shadow loading.
module multiplex_display_n
    import mux_display_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_suppress,
    input  logic                  load,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   anode,
    output logic                  frame_tick
);

    localparam int MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] B_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
    // With no blanking gap the BLANK phase never exists, so start straight in ON.
    localparam mux_state_t RST_STATE = (BLANK_CYCLES > 0) ? BLANK : ON;

    mux_state_t                 state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       pending_q, pending_d;
    logic [N_DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [N_DIGITS-1:0]        sdp_q, sdp_d;

    logic       capture;
    logic       upper_nz, suppressed, lit;
    logic [3:0] sel_digit;
    logic       sel_dp;
    logic [6:0] seg_hi;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            BLANK: begin
                if (cnt_q == B_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if (cnt_q == R_LAST) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
                    state_d = (BLANK_CYCLES > 0) ? BLANK : ON;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign frame_tick = (state_q == ON) && (idx_q == I_LAST) && (cnt_q == R_LAST);
    assign capture    = frame_tick && (pending_q || load);

    always_comb begin
        shadow_d  = capture ? digits : shadow_q;
        sdp_d     = capture ? dp_in : sdp_q;
        pending_d = capture ? 1'b0 : (pending_q | load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            sdp_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            sdp_q     <= sdp_d;
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_q) && shadow_q[j] != 4'h0) upper_nz = 1'b1;
        end
        sel_digit  = shadow_q[idx_q];
        sel_dp     = sdp_q[idx_q];
        suppressed = lz_suppress && (idx_q != '0) && !upper_nz && !sel_dp;
        lit        = (state_q == ON) && digit_en[idx_q] && !suppressed;
    end

    seg7_decoder u_dec (
        .value (sel_digit),
        .seg   (seg_hi)
    );

    always_comb begin
        anode    = (lit ? (N_DIGITS'(1) << idx_q) : '0) ^ {N_DIGITS{AN_ACTIVE_LOW}};
        segments = (lit ? seg_hi : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
        dp       = (lit & sel_dp) ^ SEG_ACTIVE_LOW;
    end

endmodule

// File: tb/tb_multiplex_display_n.sv
// Directed bench for multiplex_display_n (N=4, REFRESH=4, BLANK=1) with a
// cycle-position reference model feeding an expected-output scoreboard.
module tb_multiplex_display_n;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int SLOT = R + B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'b1111;
    logic        lz_suppress = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_tick;

    always #5 clk = ~clk;

    multiplex_display_n #(
        .N_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in),
        .digit_en(digit_en), .lz_suppress(lz_suppress), .load(load),
        .segments(segments), .dp(dp), .anode(anode), .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          t;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_pend;

    function automatic exp_t model();
        exp_t       e;
        int         slot, phase;
        logic       supp, lit;
        logic [3:0] nib;
        slot   = (t / SLOT) % N;
        phase  = t % SLOT;
        e.tick = (slot == N - 1) && (phase == SLOT - 1);
        supp   = lz_suppress && (slot != 0) && ((m_dig >> (4 * slot)) == 16'h0) && !m_dp[slot];
        lit    = (phase >= B) && digit_en[slot] && !supp;
        nib    = m_dig[4 * slot +: 4];
        e.an   = lit ? 4'(1 << slot) : 4'b0000;
        e.seg  = lit ? ~HEX[nib] : 7'h7F;
        e.dp   = lit ? ~m_dp[slot] : 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, obs, exp);
        end
    endtask

    // Called at a negedge: check this cycle, advance the model across the next edge.
    task automatic cyc();
        exp_t e;
        sb.push_back(model());
        e = sb.pop_front();
        chk("anode", 16'(anode), 16'(e.an));
        chk("segments", 16'(segments), 16'(e.seg));
        chk("dp", 16'(dp), 16'(e.dp));
        chk("frame_tick", 16'(frame_tick), 16'(e.tick));
        if (e.tick && (m_pend || load)) begin
            m_dig  = digits;
            m_dp   = dp_in;
            m_pend = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        t = 0; m_dig = '0; m_dp = '0; m_pend = 1'b0;
    endtask

    initial begin
        int k;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_anode", 16'(anode), 16'h0);
        chk("rst_segments", 16'(segments), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        rst_n = 1'b1;

        // Load 0x1234; first frame shows reset zeros, then the loaded value.
        digits = 16'h1234; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (47) cyc();

        // Mid-frame load must not tear the current frame.
        digits = 16'hABCD; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (40) cyc();

        // Leading-zero suppression, then dp override on the top digit.
        digits = 16'h0050; dp_in = 4'b0000; lz_suppress = 1'b1; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (40) cyc();
        dp_in = 4'b1000; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (40) cyc();

        digit_en = 4'b1011;
        repeat (20) cyc();

        // Asynchronous reset in the middle of slot 2's ON phase.
        k = 0;
        while (!(((t / SLOT) % N == 2) && (t % SLOT == 2)) && k < 40) begin
            cyc();
            k++;
        end
        load  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_anode", 16'(anode), 16'h0);
        chk("midrst_tick", 16'(frame_tick), 16'h0);
        chk("midrst_segments", 16'(segments), 16'h7F);
        model_reset();
        repeat (2) @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (12) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
